// File: rtl/run_controller.sv
// Launch/supervise controller for a CPU core: holds the core in reset after start,
// then counts cycles and retirements in RUN until halt (DONE) or timeout/hang (FAULT).
module run_controller #(
    parameter int RST_CYCLES  = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100000,
    parameter int STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire_valid,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_STALL   = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [STALL_W-1:0] stall_cnt, stall_nxt, stall_inc;
    logic [CNT_W-1:0]   cyc_nxt, ret_nxt, cyc_inc, ret_inc;
    logic               done_nxt, fault_nxt;
    logic [1:0]         cause_nxt;

    // Saturating increments; TIMEOUT is below all-ones so saturation never masks it.
    assign cyc_inc   = (cycle_count  == '1) ? cycle_count  : cycle_count  + 1'b1;
    assign ret_inc   = (retire_count == '1) ? retire_count : retire_count + 1'b1;
    assign stall_inc = stall_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stall_nxt = stall_cnt;
        cyc_nxt   = cycle_count;
        ret_nxt   = retire_count;
        done_nxt  = done;
        fault_nxt = fault;
        cause_nxt = fault_cause;

        case (state)
            IDLE, DONE, FAULT: begin
                if (start) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_W'(RST_CYCLES - 1);
                    stall_nxt = '0;
                    cyc_nxt   = '0;
                    ret_nxt   = '0;
                    done_nxt  = 1'b0;
                    fault_nxt = 1'b0;
                    cause_nxt = CAUSE_NONE;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = RUN;
                    stall_nxt = '0;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            RUN: begin
                cyc_nxt = cyc_inc;
                if (retire_valid) begin
                    ret_nxt   = ret_inc;
                    stall_nxt = '0;
                end else begin
                    stall_nxt = stall_inc;
                end
                // Halt beats timeout beats stall; a retiring cycle can never stall.
                if (retire_valid && halt_req) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (cyc_inc == CNT_W'(TIMEOUT)) begin
                    state_nxt = FAULT;
                    fault_nxt = 1'b1;
                    cause_nxt = CAUSE_TIMEOUT;
                end else if (!retire_valid && stall_inc == STALL_W'(STALL_LIMIT)) begin
                    state_nxt = FAULT;
                    fault_nxt = 1'b1;
                    cause_nxt = CAUSE_STALL;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            stall_cnt    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            done         <= 1'b0;
            fault        <= 1'b0;
            fault_cause  <= CAUSE_NONE;
            cpu_rst      <= 1'b1;
            running      <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            stall_cnt    <= stall_nxt;
            cycle_count  <= cyc_nxt;
            retire_count <= ret_nxt;
            done         <= done_nxt;
            fault        <= fault_nxt;
            fault_cause  <= cause_nxt;
            cpu_rst      <= (state_nxt != RUN);
            running      <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: launch hold, halt, stall and timeout faults,
// cause priority, restart from DONE and reset mid-run.
module tb_run_controller;

    localparam int RST_CYCLES  = 4;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT     = 50;
    localparam int STALL_LIMIT = 16;

    if (TIMEOUT >= (1 << CNT_W)) begin : g_timeout_fits
        $error("TIMEOUT does not fit in CNT_W");
    end

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             retire_valid = 1'b0;
    logic             halt_req = 1'b0;
    logic             cpu_rst, running, done, fault;
    logic [1:0]       fault_cause;
    logic [CNT_W-1:0] cycle_count, retire_count;

    int checks   = 0;
    int failures = 0;

    run_controller #(
        .RST_CYCLES (RST_CYCLES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .retire_valid(retire_valid),
        .halt_req    (halt_req),
        .cpu_rst     (cpu_rst),
        .running     (running),
        .done        (done),
        .fault       (fault),
        .fault_cause (fault_cause),
        .cycle_count (cycle_count),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic hr);
        retire_valid = rv;
        halt_req     = hr;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; retire_valid = 1'b0; halt_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Pulse start and wait (bounded) until the first RUN cycle is visible.
    task automatic launch();
        int n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!running && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!running || cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL launch: running=%0b cycle_count=%0d after %0d cycles, required running=1 cycle_count=0",
                     running, cycle_count, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        step();
        checks++;
        if ({cpu_rst, running, done, fault, fault_cause} !== 6'b100000 ||
            cycle_count !== 8'd0 || retire_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: flags=%b cyc=%0d ret=%0d, required flags=100000 cyc=0 ret=0",
                     {cpu_rst, running, done, fault, fault_cause}, cycle_count, retire_count);
        end
        rst = 1'b0; start = 1'b0;
        repeat (5) step();
        checks++;
        if (cpu_rst !== 1'b1 || running !== 1'b0 || cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL idle_until_start: cpu_rst=%0b running=%0b cyc=%0d, required 1 0 0",
                     cpu_rst, running, cycle_count);
        end
    endtask

    task automatic test_launch();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= RST_CYCLES; i++) begin
            checks++;
            if (cpu_rst !== 1'b1 || running !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle_%0d: cpu_rst=%0b running=%0b, required 1 0", i, cpu_rst, running);
            end
            if (i < RST_CYCLES) step();
        end
        step();
        checks++;
        if (cpu_rst !== 1'b0 || running !== 1'b1 || cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL run_entry: cpu_rst=%0b running=%0b cyc=%0d, required 0 1 0",
                     cpu_rst, running, cycle_count);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (cycle_count !== 8'(i)) begin
                failures++;
                $display("FAIL cycle_count_%0d: got %0d, required %0d", i, cycle_count, i);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || cpu_rst !== 1'b0 || cycle_count !== 8'd4) begin
            failures++;
            $display("FAIL start_in_run: running=%0b cpu_rst=%0b cyc=%0d, required 1 0 4",
                     running, cpu_rst, cycle_count);
        end
    endtask

    task automatic test_halt_and_restart();
        do_reset();
        launch();
        for (int i = 1; i <= 10; i++) drive(1'b1, i == 10);
        retire_valid = 1'b0; halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || retire_count !== 8'd10 || cycle_count !== 8'd10 ||
            cpu_rst !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL halt: done=%0b fault=%0b ret=%0d cyc=%0d cpu_rst=%0b running=%0b, required 1 0 10 10 1 0",
                     done, fault, retire_count, cycle_count, cpu_rst, running);
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        checks++;
        if (done !== 1'b1 || retire_count !== 8'd10 || cycle_count !== 8'd10) begin
            failures++;
            $display("FAIL done_frozen: done=%0b ret=%0d cyc=%0d, required 1 10 10", done, retire_count, cycle_count);
        end
        retire_valid = 1'b0; halt_req = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || fault !== 1'b0 || retire_count !== 8'd0 || cycle_count !== 8'd0 ||
            cpu_rst !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL restart_from_done: done=%0b fault=%0b ret=%0d cyc=%0d cpu_rst=%0b running=%0b, required 0 0 0 0 1 0",
                     done, fault, retire_count, cycle_count, cpu_rst, running);
        end
        repeat (RST_CYCLES) step();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL rehold_length: running=%0b, required 1", running);
        end
    endtask

    task automatic test_stall();
        do_reset();
        launch();
        // halt_req without retire_valid must be ignored throughout
        for (int i = 1; i < STALL_LIMIT; i++) drive(1'b0, 1'b1);
        checks++;
        if (fault !== 1'b0 || done !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL stall_early: fault=%0b done=%0b running=%0b, required 0 0 1", fault, done, running);
        end
        drive(1'b0, 1'b1);
        halt_req = 1'b0;
        checks++;
        if (fault !== 1'b1 || done !== 1'b0 || fault_cause !== 2'b10 || retire_count !== 8'd0 ||
            cycle_count !== 8'd16 || running !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL stall_fault: fault=%0b done=%0b cause=%b ret=%0d cyc=%0d running=%0b cpu_rst=%0b, required 1 0 10 0 16 0 1",
                     fault, done, fault_cause, retire_count, cycle_count, running, cpu_rst);
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        launch();
        repeat (15) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (15) drive(1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0 || running !== 1'b1 || cycle_count !== 8'd31 || retire_count !== 8'd1) begin
            failures++;
            $display("FAIL stall_cleared_by_retire: fault=%0b running=%0b cyc=%0d ret=%0d, required 0 1 31 1",
                     fault, running, cycle_count, retire_count);
        end
        drive(1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'b10 || cycle_count !== 8'd32) begin
            failures++;
            $display("FAIL stall_after_retire: fault=%0b cause=%b cyc=%0d, required 1 10 32", fault, fault_cause, cycle_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        launch();
        repeat (TIMEOUT - 1) drive(1'b1, 1'b0);
        checks++;
        if (fault !== 1'b0 || running !== 1'b1 || cycle_count !== 8'd49) begin
            failures++;
            $display("FAIL timeout_early: fault=%0b running=%0b cyc=%0d, required 0 1 49", fault, running, cycle_count);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (fault !== 1'b1 || done !== 1'b0 || fault_cause !== 2'b01 || cycle_count !== 8'd50 ||
            retire_count !== 8'd50) begin
            failures++;
            $display("FAIL timeout_fault: fault=%0b done=%0b cause=%b cyc=%0d ret=%0d, required 1 0 01 50 50",
                     fault, done, fault_cause, cycle_count, retire_count);
        end
        repeat (3) drive(1'b1, 1'b1);
        retire_valid = 1'b0; halt_req = 1'b0;
        checks++;
        if (fault !== 1'b1 || done !== 1'b0 || cycle_count !== 8'd50 || retire_count !== 8'd50) begin
            failures++;
            $display("FAIL fault_frozen: fault=%0b done=%0b cyc=%0d ret=%0d, required 1 0 50 50",
                     fault, done, cycle_count, retire_count);
        end
    endtask

    task automatic test_halt_at_timeout();
        do_reset();
        launch();
        repeat (TIMEOUT - 1) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        retire_valid = 1'b0; halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || fault_cause !== 2'b00 || cycle_count !== 8'd50) begin
            failures++;
            $display("FAIL halt_beats_timeout: done=%0b fault=%0b cause=%b cyc=%0d, required 1 0 00 50",
                     done, fault, fault_cause, cycle_count);
        end
    endtask

    task automatic test_timeout_beats_stall();
        do_reset();
        launch();
        repeat (TIMEOUT - STALL_LIMIT) drive(1'b1, 1'b0);
        repeat (STALL_LIMIT - 1) drive(1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0 || cycle_count !== 8'd49) begin
            failures++;
            $display("FAIL coincide_early: fault=%0b cyc=%0d, required 0 49", fault, cycle_count);
        end
        drive(1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'b01) begin
            failures++;
            $display("FAIL timeout_beats_stall: fault=%0b cause=%b, required 1 01", fault, fault_cause);
        end
    endtask

    task automatic test_rst_mid_run();
        do_reset();
        launch();
        repeat (5) drive(1'b1, 1'b0);
        rst = 1'b1; start = 1'b1;
        step();
        checks++;
        if ({cpu_rst, running, done, fault, fault_cause} !== 6'b100000 ||
            cycle_count !== 8'd0 || retire_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_run: flags=%b cyc=%0d ret=%0d, required flags=100000 cyc=0 ret=0",
                     {cpu_rst, running, done, fault, fault_cause}, cycle_count, retire_count);
        end
        rst = 1'b0; start = 1'b0; retire_valid = 1'b0;
        repeat (RST_CYCLES + 2) step();
        checks++;
        if (running !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_rst: running=%0b cpu_rst=%0b, required 0 1", running, cpu_rst);
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_halt_and_restart();
        test_stall();
        test_stall_reset();
        test_timeout();
        test_halt_at_timeout();
        test_timeout_beats_stall();
        test_rst_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- RST_CYCLES, 4, cycles cpu_rst is held after start (>=1).
- CNT_W, 32, width of cycle/retire counters.
- TIMEOUT, 100000, maximum RUN cycles before fault.
- STALL_LIMIT, 16, maximum consecutive RUN cycles without retire before fault.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, single clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request to (re)launch the CPU.
- retire_valid, input, 1, one instruction retired in WB this cycle.
- halt_req, input, 1, retiring instruction is ebreak/ecall; qualified by retire_valid.
- cpu_rst, output, 1, synchronous active-high reset driven to the CPU core.
- running, output, 1, state is RUN.
- done, output, 1, sticky: program halted normally.
- fault, output, 1, sticky: timeout or hang.
- fault_cause, output, 2, 00 none, 01 timeout, 10 stall.
- cycle_count, output, CNT_W, RUN cycles elapsed.
- retire_count, output, CNT_W, instructions retired.

REQ-003 All outputs SHALL be registered, with no combinational input-to-output path.

Function
REQ-004 The FSM SHALL have states IDLE, HOLD, RUN, DONE and FAULT.

REQ-005 In IDLE, cpu_rst=1; start=1 -> HOLD, with the hold counter loaded to RST_CYCLES-1 and cycle_count, retire_count, done, fault and fault_cause cleared on the same edge.

REQ-006 In HOLD, cpu_rst=1 for exactly RST_CYCLES cycles; the transition to RUN occurs on the edge after the hold counter reaches 0; start is ignored in HOLD.

REQ-007 In RUN:
- cpu_rst=0 and running=1.
- cycle_count increments by 1 every cycle, saturating at all-ones.
- retire_count increments on retire_valid=1, saturating.

REQ-008 In RUN, retire_valid=1 with halt_req=1 -> DONE, done=1, and that retirement is counted in retire_count.

REQ-009 halt_req with retire_valid=0 SHALL be ignored.

REQ-010 The stall counter:
- resets to 0 on any retire_valid and on RUN entry;
- otherwise increments each RUN cycle;
- on reaching STALL_LIMIT -> FAULT with fault_cause=10.

REQ-011 When cycle_count reaches TIMEOUT (on the edge where it would become TIMEOUT) -> FAULT with fault_cause=01.

REQ-012 Priority on simultaneous events in the same cycle: halt > timeout > stall; only one cause is ever recorded.

REQ-013 start asserted in RUN SHALL be ignored (no restart mid-run).

REQ-014 In DONE and FAULT:
- cpu_rst=1 and running=0;
- counters and flags are frozen;
- start=1 -> HOLD with the clears of REQ-005.

REQ-015 done and fault SHALL never both be 1.

REQ-016 TIMEOUT SHALL be less than 2^CNT_W; the bench checks this with an elaboration-time assertion.

Reset
REQ-017 rst=1 on a rising edge, from any state, SHALL force:
- state IDLE, hold and stall counters to 0;
- cpu_rst=1, running=0, done=0, fault=0, fault_cause=00;
- cycle_count=0, retire_count=0.

REQ-018 rst SHALL dominate start in the same cycle.

REQ-019 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-020 Reset then start pulse, RST_CYCLES=4 -> cpu_rst high for exactly 4 cycles after the start edge, then running=1 and cycle_count counts 1,2,3,...

REQ-021 In RUN, retire every cycle for 10 cycles, with halt_req on the 10th -> done=1 next edge, retire_count=10, cycle_count=10, cpu_rst=1, running=0.

REQ-022 STALL_LIMIT=16, no retires after RUN entry -> fault=1 with fault_cause=10 after the 16th RUN cycle; retire_count=0.

REQ-023 TIMEOUT=50, retire every cycle and never halt -> fault=1 with fault_cause=01 and cycle_count=50.

REQ-024 Halt retirement on the same cycle the timeout fires -> done=1, fault=0, fault_cause=00.

REQ-025 Two cases:
- rst asserted mid-RUN with counters nonzero -> next edge all outputs at reset values.
- start in DONE -> counters cleared and HOLD re-entered.
